// File: rtl/decode_tracker_pkg.sv
// Shared definitions for the decode tracker: instruction and register-address
// widths, the bubble encoding, the opcode map and the instruction field layout.
package decode_tracker_pkg;

  // Instruction word width and register address width.
  localparam int ISIZE = 16;
  localparam int RSIZE = 4;

  // Bubble encoding: ADD R0,R0,R0. Rd=R0, so forwarding never picks it up.
  localparam logic [ISIZE-1:0] NOP_INSTR = 16'h0000;

  // Opcode map carried in Instr[15:12].
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SRA  = 4'h8,
    OP_LHB  = 4'h9,
    OP_LLB  = 4'hA,
    OP_LW   = 4'hB,
    OP_SW   = 4'hC,
    OP_B    = 4'hD,
    OP_JAL  = 4'hE,
    OP_JR   = 4'hF
  } opcode_e;

  // Fields decoded from a single instruction word. Cond and Rd overlap on
  // purpose: which one is meaningful depends on the opcode.
  typedef struct packed {
    logic [3:0]       opcode;
    logic [2:0]       cond;
    logic [RSIZE-1:0] rd;
    logic [RSIZE-1:0] rs;
    logic [RSIZE-1:0] rt;
  } fields_t;

  // Split an instruction word into its fields.
  function automatic fields_t decode_fields(input logic [ISIZE-1:0] instr);
    fields_t f;
    f.opcode = instr[15:12];
    f.cond   = instr[11:9];
    f.rd     = instr[11:8];
    f.rs     = instr[7:4];
    f.rt     = instr[3:0];
    return f;
  endfunction

endpackage

// File: rtl/decode_tracker_flag_reg.sv
// flag_reg: holds the {N,V,Z} condition flags for the branch logic.
// Build option: define FLAG_BYPASS_EN to forward FlagIn straight to Flag in
// the cycle FlagWe is high, so a branch right behind a flag-setting
// instruction sees the new flags. Without it, Flag is the registered copy.
module flag_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] flag_in,
  input  logic       flag_we,
  output logic [2:0] flag
);

  logic [2:0] flag_q;

  // Flag register: loads on write enable, reset clears it; pipeline
  // stall/flush have no effect here.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 3'b000;
    end else if (flag_we) begin
      flag_q <= flag_in;
    end
  end

`ifdef FLAG_BYPASS_EN
  // Presented flags: incoming value while it is being written, else stored.
  always_comb begin
    flag = flag_we ? flag_in : flag_q;
  end
`else
  // Presented flags: stored value only.
  always_comb begin
    flag = flag_q;
  end
`endif

endmodule

// File: rtl/decode_tracker.sv
// decode_tracker: decode-stage pipeline register with a two-deep history of
// the instructions that left decode (used by hazard/forwarding logic), the
// combinational field decode, and the condition-flag register (flag_reg).
// Build option: FLAG_BYPASS_EN (see flag_reg).
//
// Pipeline control: Flush beats Stall. Flush loads a bubble, Stall holds the
// decode register and pushes a bubble into history, neither loads InstrIn.
// Reset beats everything and leaves no history behind.
module decode_tracker
  import decode_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ISIZE-1:0] InstrIn,
  input  logic [15:0]      PCIn,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [2:0]       FlagIn,
  input  logic             FlagWe,
  output logic [ISIZE-1:0] Instr,
  output logic [15:0]      PCOut,
  output logic             Valid,
  output logic [3:0]       OpCode,
  output logic [2:0]       Cond,
  output logic [RSIZE-1:0] AddrRd,
  output logic [RSIZE-1:0] AddrRs,
  output logic [RSIZE-1:0] AddrRt,
  output logic [ISIZE-1:0] LastInstr,
  output logic [ISIZE-1:0] Last2Instr,
  output logic [2:0]       Flag
);

  logic             stall_only;
  logic [ISIZE-1:0] retire_instr;
  fields_t          fields;

  // Stall without Flush is the only case that holds decode.
  always_comb begin
    stall_only = Stall && !Flush;
  end

  // Instruction leaving decode this cycle: a bubble when decode is held or
  // when the decode slot itself holds a bubble.
  always_comb begin
    retire_instr = NOP_INSTR;
    if (!stall_only && Valid) begin
      retire_instr = Instr;
    end
  end

  // Decode register: flush -> bubble, stall -> hold, otherwise capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      Instr <= NOP_INSTR;
      PCOut <= 16'h0000;
      Valid <= 1'b0;
    end else if (Flush) begin
      Instr <= NOP_INSTR;
      PCOut <= PCIn;
      Valid <= 1'b0;
    end else if (!Stall) begin
      Instr <= InstrIn;
      PCOut <= PCIn;
      Valid <= 1'b1;
    end
  end

  // History shift: runs every cycle, one bubble per stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      LastInstr  <= NOP_INSTR;
      Last2Instr <= NOP_INSTR;
    end else begin
      LastInstr  <= retire_instr;
      Last2Instr <= LastInstr;
    end
  end

  // Field decode straight from the decode register.
  always_comb begin
    fields = decode_fields(Instr);
    OpCode = fields.opcode;
    Cond   = fields.cond;
    AddrRd = fields.rd;
    AddrRs = fields.rs;
    AddrRt = fields.rt;
  end

  flag_reg u_flag_reg (
    .clk     (clk),
    .rst     (rst),
    .flag_in (FlagIn),
    .flag_we (FlagWe),
    .flag    (Flag)
  );

endmodule
